// File: rtl/uart_rx_if.sv
// uart_rx_if -- signal bundle between a UART serial line and its receiver.
//   rxd       : serial line, idle high, asynchronous to the receiver clock
//   axiod     : received data word
//   axiov     : one-cycle valid strobe qualifying axiod
//   frame_err : one-cycle strobe reporting a bad stop bit
// Modports:
//   master : line/consumer side (drives rxd, observes the results)
//   slave  : receiver side (samples rxd, drives the results)
`timescale 1ns/100ps
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rxd;
  logic [DATA_WIDTH-1:0] axiod;
  logic                  axiov;
  logic                  frame_err;

  modport master (output rxd, input axiod, input axiov, input frame_err);
  modport slave  (input rxd, output axiod, output axiov, output frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1-style UART receiver, LSB first, one stop bit.
// Ports:
//   clk : single clock, all state updates on its rising edge
//   rst : asynchronous, active-low reset
//   bus : uart_rx_if.slave -- rxd in; axiod / axiov / frame_err out
// A good frame loads axiod and pulses axiov for one cycle. A low stop
// bit pulses frame_err once and then waits for the line to return high,
// so a long break reports only a single error.
`timescale 1ns/100ps
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 0,
  parameter int BAUDRATE    = 0
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  // Guard against the zero defaults so the block still elaborates; a
  // real instance always overrides both rate parameters.
  localparam int BAUD_RAW    = (BAUDRATE > 0) ? (CLK_FREQ_HZ / BAUDRATE) : 2;
  localparam int BAUD_PERIOD = (BAUD_RAW >= 2) ? BAUD_RAW : 2;
  localparam int CNT_W       = $clog2(BAUD_PERIOD);
  localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BAUD_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] axiod_r;
  logic                  axiov_r;
  logic                  frame_err_r;
  logic                  rxd_meta_r;
  logic                  rxd_s;

  assign bus.axiod     = axiod_r;
  assign bus.axiov     = axiov_r;
  assign bus.frame_err = frame_err_r;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_r <= 1'b1;
      rxd_s      <= 1'b1;
    end else begin
      rxd_meta_r <= bus.rxd;
      rxd_s      <= rxd_meta_r;
    end
  end

  // Receive FSM with baud counter, bit index, shift register and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= IDX_ZERO;
      shift_r     <= {DATA_WIDTH{1'b0}};
      axiod_r     <= {DATA_WIDTH{1'b0}};
      axiov_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are only set on the sample edge.
      axiov_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= IDX_ZERO;
          if (!rxd_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          // Re-check the start bit at its centre; a high line is a glitch.
          if (cnt_r == HALF_M1) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= IDX_ZERO;
            if (!rxd_s) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          // Counter is now phase-aligned to bit centres; edges are ignored.
          if (cnt_r == FULL_M1) begin
            cnt_r              <= CNT_ZERO;
            shift_r[bit_idx_r] <= rxd_s;
            if (bit_idx_r == IDX_LAST) begin
              bit_idx_r <= IDX_ZERO;
              state_r   <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + IDX_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r <= CNT_ZERO;
            if (rxd_s) begin
              axiod_r <= shift_r;
              axiov_r <= 1'b1;
              state_r <= IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          // Hold off through a break so it yields one error, not many.
          cnt_r <= CNT_ZERO;
          if (rxd_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_IDLE;
          end
        end
        default: begin
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= IDX_ZERO;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
